// File: rtl/chunked_adder_seq_pkg.sv
// Shared definitions for the chunked wide adder: FSM state encoding and
// default operand/slice widths.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SLICE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index counter width; never zero even when only one slice exists.
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/chunked_adder_seq_if.sv
// Operand request and result handshakes of the chunked adder.
// master drives operands and accepts results; slave is the adder itself.
interface chunked_adder_seq_if #(
    parameter int WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );

endinterface

// File: rtl/chunked_adder_seq_slice_adder.sv
// Narrow combinational ripple adder, one full adder per bit. Each stage
// keeps its own carry wire and reads the previous stage's carry by name,
// so the chain is a set of distinct nets rather than one self-feeding vector.
module slice_adder #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    for (genvar gi = 0; gi < SLICE; gi++) begin : g_fa
        logic c_in;
        logic c_out;

        if (gi == 0) begin : g_first
            assign c_in = cin;
        end else begin : g_rest
            assign c_in = g_fa[gi-1].c_out;
        end

        assign sum[gi] = a[gi] ^ b[gi] ^ c_in;
        assign c_out   = (a[gi] & b[gi]) | (c_in & (a[gi] ^ b[gi]));
    end

    assign cout = g_fa[SLICE-1].c_out;

endmodule

// File: rtl/chunked_adder_seq.sv
// Multi-cycle wide adder: captures two WIDTH-bit operands, then walks one
// shared SLICE-bit adder across them LSB slice first, carrying through a
// register, and presents sum/cout until the consumer takes them.
// WIDTH must be an exact multiple of SLICE.
module chunked_adder_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SLICE = DEFAULT_SLICE
) (
    input logic                clk,
    input logic                rst_n,
    chunked_adder_seq_if.slave bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = idx_width(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [IDX_W-1:0] idx_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic             carry_reg;
    logic             cout_reg;

    logic [SLICE-1:0] a_chunk [NSLICE];
    logic [SLICE-1:0] b_chunk [NSLICE];
    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;

    logic             accept;
    logic             last_slice;

    assign accept     = (state_reg == IDLE) && bus.in_valid;
    assign last_slice = (state_reg == RUN) && (idx_reg == LAST_IDX);

    // Split the captured operands into slice-sized chunks.
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_chunk
        assign a_chunk[gi] = a_reg[gi*SLICE +: SLICE];
        assign b_chunk[gi] = b_reg[gi*SLICE +: SLICE];
    end

    // Route the chunk selected by idx into the shared adder.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                slice_a = a_chunk[i];
                slice_b = b_chunk[i];
            end
        end
    end

    slice_adder #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Merge this cycle's slice result into its position of the running sum.
    always_comb begin
        sum_next = sum_reg;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                sum_next[i*SLICE +: SLICE] = slice_sum;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state: accept, walk every slice once, then hold until taken.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid)        state_next = RUN;
            RUN:     if (idx_reg == LAST_IDX) state_next = DONE;
            DONE:    if (bus.out_ready)       state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, then one slice per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
        end else if (accept) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= bus.cin;
            sum_reg   <= '0;
            idx_reg   <= '0;
        end else if (state_reg == RUN) begin
            sum_reg   <= sum_next;
            carry_reg <= slice_cout;
            // Wrap explicitly so a non-power-of-two slice count starts clean.
            idx_reg   <= last_slice ? '0 : idx_reg + 1'b1;
            if (last_slice) begin
                cout_reg <= slice_cout;
            end
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;

endmodule
